timer_ctrl_fsm: RTL and testbench

Sequencing controller for the 4-digit BCD stopwatch/countdown datapath. It turns the debounced front-panel buttons and keypad codes into run/pause/load/clear commands for the BCD counter, and owns the preset entered in configuration mode. It sits between the keypad scanner and button inputs on one side and the BCD counter and display mux on the other.

---
 rtl/timer_ctrl_fsm_if.sv | 24 ++
 rtl/timer_ctrl_fsm.sv | 173 +++++++++++++++++
 tb/tb_timer_ctrl_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_fsm_if.sv
// Keypad and BCD-counter side of the stopwatch/countdown controller.
// The controller takes the master modport; the counter/keypad side takes the slave modport.
interface timer_ctrl_fsm_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        tick;
   logic        cnt_zero;
   logic        cnt_max;
   logic        cnt_en;
   logic        cnt_dir;
   logic        cnt_load;
   logic [15:0] load_value;
   logic        cnt_clr;

   modport master (
      input  key_valid, key_code, tick, cnt_zero, cnt_max,
      output cnt_en, cnt_dir, cnt_load, load_value, cnt_clr
   );

   modport slave (
      output key_valid, key_code, tick, cnt_zero, cnt_max,
      input  cnt_en, cnt_dir, cnt_load, load_value, cnt_clr
   );
endinterface

// File: rtl/timer_ctrl_fsm.sv
// Run/pause/config sequencer for the 4-digit BCD stopwatch/countdown counter.
// Buttons are synchronized and edge-detected; keypad codes edit the preset in CONFIG.
module timer_ctrl_fsm #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reseta,
   input  logic                   pause,
   input  logic                   cfg,
   input  logic                   sel,
   timer_ctrl_fsm_if.master       bus,
   output logic [15:0]            preset,
   output logic [2:0]             state,
   output logic                   running,
   output logic                   done
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync_stages
         $error("timer_ctrl_fsm: SYNC_STAGES must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CONFIG = 3'd1,
      S_RUN    = 3'd2,
      S_PAUSED = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] preset_q, preset_d;
   logic        dir_q, dir_d;
   logic        load_q, load_d;
   logic        clr_q, clr_d;
   logic [15:0] lv_q, lv_d;

   logic [SYNC_STAGES-1:0] pause_sync, cfg_sync;
   logic                   pause_prev, cfg_prev;
   logic                   pause_evt, cfg_evt;
   logic                   key_clr;
   logic                   hit;

   // Digits shift in from the right; backspace drops the newest digit.
   function automatic logic [15:0] preset_edit(input logic [15:0] cur, input logic [3:0] key);
      logic [15:0] nxt;
      nxt = cur;
      if (key <= 4'h9)
         nxt = {cur[11:0], key};
      else if (key == 4'hA)
         nxt = 16'h0000;
      else if (key == 4'hB)
         nxt = {4'h0, cur[15:4]};
      return nxt;
   endfunction

   // Button synchronizers; idle level is high, so everything resets to 1.
   always_ff @(posedge clk or negedge reseta) begin
      if (!reseta) begin
         pause_sync <= '1;
         cfg_sync   <= '1;
         pause_prev <= 1'b1;
         cfg_prev   <= 1'b1;
      end else begin
         pause_sync <= {pause_sync[SYNC_STAGES-2:0], pause};
         cfg_sync   <= {cfg_sync[SYNC_STAGES-2:0], cfg};
         pause_prev <= pause_sync[SYNC_STAGES-1];
         cfg_prev   <= cfg_sync[SYNC_STAGES-1];
      end
   end

   assign pause_evt = pause_prev & ~pause_sync[SYNC_STAGES-1];
   assign cfg_evt   = cfg_prev & ~cfg_sync[SYNC_STAGES-1];
   assign key_clr   = bus.key_valid && (bus.key_code == 4'hA);
   assign hit       = dir_q ? bus.cnt_zero : bus.cnt_max;

   always_ff @(posedge clk or negedge reseta) begin
      if (!reseta)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      preset_d = preset_q;
      dir_d    = dir_q;
      load_d   = 1'b0;
      clr_d    = 1'b0;
      lv_d     = lv_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_evt) begin
               state_d = S_CONFIG;
            end else if (pause_evt) begin
               if (!sel) begin
                  state_d = S_RUN;
                  load_d  = 1'b1;
                  lv_d    = 16'h0000;
                  dir_d   = 1'b0;
               end else if (preset_q != 16'h0000) begin
                  state_d = S_RUN;
                  load_d  = 1'b1;
                  lv_d    = preset_q;
                  dir_d   = 1'b1;
               end
            end
         end
         S_CONFIG: begin
            if (bus.key_valid)
               preset_d = preset_edit(preset_q, bus.key_code);
            if (cfg_evt) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end
         end
         S_RUN: begin
            // Terminal count takes priority over a simultaneous pause press.
            if (hit)
               state_d = S_DONE;
            else if (pause_evt)
               state_d = S_PAUSED;
         end
         S_PAUSED: begin
            if (pause_evt) begin
               state_d = S_RUN;
            end else if (key_clr) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end
         end
         S_DONE: begin
            if (pause_evt || key_clr) begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reseta) begin
      if (!reseta) begin
         preset_q <= 16'h0000;
         dir_q    <= 1'b0;
         load_q   <= 1'b0;
         clr_q    <= 1'b0;
         lv_q     <= 16'h0000;
      end else begin
         preset_q <= preset_d;
         dir_q    <= dir_d;
         load_q   <= load_d;
         clr_q    <= clr_d;
         lv_q     <= lv_d;
      end
   end

   assign state   = state_q;
   assign preset  = preset_q;
   assign running = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);

   // A tick landing on the load cycle is dropped so the loaded value is not stepped.
   assign bus.cnt_en     = running & bus.tick & ~hit & ~load_q;
   assign bus.cnt_dir    = running & dir_q;
   assign bus.cnt_load   = load_q;
   assign bus.cnt_clr    = clr_q;
   assign bus.load_value = lv_q;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Directed vector bench for timer_ctrl_fsm: per-cycle stimulus/expectation table
// plus hand-written sequences for preset retention and asynchronous reset mid-run.
module tb_timer_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reseta = 1'b0;
   logic        pause = 1'b1;
   logic        cfg = 1'b1;
   logic        sel = 1'b0;
   logic [15:0] preset;
   logic [2:0]  state;
   logic        running;
   logic        done;

   timer_ctrl_fsm_if bus();

   timer_ctrl_fsm #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reseta  (reseta),
      .pause   (pause),
      .cfg     (cfg),
      .sel     (sel),
      .bus     (bus),
      .preset  (preset),
      .state   (state),
      .running (running),
      .done    (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        p, c, s, kv;
      logic [3:0]  kc;
      logic        t, z, m;
      logic [2:0]  st;
      logic        en, dir, ld, clr;
      logic [15:0] lv, pre;
   } vec_t;

   vec_t vecs[$];
   int   nvec = 0;
   int   nbad = 0;

   function automatic vec_t mk(input string nm,
                               input logic p, input logic c, input logic s, input logic kv,
                               input logic [3:0] kc, input logic t, input logic z, input logic m,
                               input logic [2:0] st, input logic en, input logic dir,
                               input logic ld, input logic clr,
                               input logic [15:0] lv, input logic [15:0] pre);
      vec_t v;
      v.nm = nm; v.p = p; v.c = c; v.s = s; v.kv = kv; v.kc = kc;
      v.t = t; v.z = z; v.m = m; v.st = st; v.en = en; v.dir = dir;
      v.ld = ld; v.clr = clr; v.lv = lv; v.pre = pre;
      return v;
   endfunction

   // {state, running, done, cnt_en, cnt_dir, cnt_load, cnt_clr, load_value, preset}
   function automatic logic [40:0] dut_out();
      return {state, running, done, bus.cnt_en, bus.cnt_dir, bus.cnt_load, bus.cnt_clr,
              bus.load_value, preset};
   endfunction

   function automatic logic [40:0] exp_out(input vec_t v);
      return {v.st, (v.st == 3'd2), (v.st == 3'd4), v.en, v.dir, v.ld, v.clr, v.lv, v.pre};
   endfunction

   task automatic check(input string nm, input logic [40:0] got, input logic [40:0] expv);
      nvec++;
      if (got !== expv) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, got, expv);
      end
   endtask

   task automatic press(input bit is_cfg);
      @(negedge clk);
      if (is_cfg) cfg = 1'b0; else pause = 1'b0;
      @(negedge clk);
      @(negedge clk);
      pause = 1'b1;
      cfg   = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      bus.tick      = 1'b0;
      bus.cnt_zero  = 1'b0;
      bus.cnt_max   = 1'b0;

      //            name            p c s kv kc    t z m  st en dr ld cl lv        pre
      vecs.push_back(mk("sa_fall",    0,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("sa_sync1",   0,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("sa_evt",     0,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("sa_load",    0,1,0,0,4'h0,0,0,0, 2,0,0,1,0,16'h0000,16'h0000));
      vecs.push_back(mk("sa_tick",    0,1,0,0,4'h0,1,0,0, 2,1,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("sa_rel",     1,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("sa_hold1",   1,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("sa_one_evt", 1,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("pz_press0",  0,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("pz_press1",  0,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("pz_evt",     1,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("pz_tick",    1,1,0,0,4'h0,1,0,0, 3,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("pz_tick2",   0,1,1,0,4'h0,1,0,0, 3,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("rs_press",   0,1,1,0,4'h0,0,0,0, 3,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("rs_evt",     1,1,1,0,4'h0,0,0,0, 3,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("rs_noload",  1,1,1,0,4'h0,1,0,0, 2,1,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("rs_sel0",    1,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("up_max",     1,1,0,0,4'h0,1,0,1, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("up_done",    1,1,0,0,4'h0,1,0,0, 4,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("dn_press0",  0,1,0,0,4'h0,0,0,0, 4,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("dn_press1",  0,1,0,0,4'h0,0,0,0, 4,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("dn_evt",     1,1,0,0,4'h0,0,0,0, 4,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("dn_clr",     1,1,0,0,4'h0,0,0,0, 0,0,0,0,1,16'h0000,16'h0000));
      vecs.push_back(mk("idle",       1,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("cf_press0",  1,0,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("cf_press1",  1,0,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("cf_evt",     1,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("key1",       1,1,0,1,4'h1,0,0,0, 1,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("key2",       1,1,0,1,4'h2,0,0,0, 1,0,0,0,0,16'h0000,16'h0001));
      vecs.push_back(mk("key3",       1,1,0,1,4'h3,0,0,0, 1,0,0,0,0,16'h0000,16'h0012));
      vecs.push_back(mk("key4",       1,1,0,1,4'h4,0,0,0, 1,0,0,0,0,16'h0000,16'h0123));
      vecs.push_back(mk("keyB",       1,1,0,1,4'hB,0,0,0, 1,0,0,0,0,16'h0000,16'h1234));
      vecs.push_back(mk("key5",       1,1,0,1,4'h5,0,0,0, 1,0,0,0,0,16'h0000,16'h0123));
      vecs.push_back(mk("keyC",       1,1,0,1,4'hC,0,0,0, 1,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("cf_pz0",     0,1,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("cf_pz1",     0,1,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("cf_pzevt",   1,1,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("cf_exit0",   1,0,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("cf_exit1",   1,0,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("cf_exitevt", 1,1,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("cf_clr",     1,1,0,0,4'h0,0,0,0, 0,0,0,0,1,16'h0000,16'h1235));
      vecs.push_back(mk("dn_start0",  0,1,1,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("dn_start1",  0,1,1,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("dn_startevt",1,1,1,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h1235));
      vecs.push_back(mk("dn_load",    1,1,1,0,4'h0,1,0,0, 2,0,1,1,0,16'h1235,16'h1235));
      vecs.push_back(mk("dn_tick",    1,1,1,0,4'h0,1,0,0, 2,1,1,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("dn_selchg",  1,1,0,0,4'h0,0,0,0, 2,0,1,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("hp_press0",  0,1,0,0,4'h0,0,0,0, 2,0,1,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("hp_press1",  0,1,0,0,4'h0,0,0,0, 2,0,1,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("hit_and_pz", 1,1,0,0,4'h0,1,1,0, 2,0,1,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("done_keyA",  1,1,0,1,4'hA,0,0,0, 4,0,0,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("done_clr",   1,1,0,0,4'h0,0,0,0, 0,0,0,0,1,16'h1235,16'h1235));
      vecs.push_back(mk("zc_press0",  1,0,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("zc_press1",  1,0,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("zc_evt",     1,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("zc_keyA",    1,1,0,1,4'hA,0,0,0, 1,0,0,0,0,16'h1235,16'h1235));
      vecs.push_back(mk("zc_exit0",   1,0,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("zc_exit1",   1,0,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("zc_exitevt", 1,1,0,0,4'h0,0,0,0, 1,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("zc_clr",     1,1,0,0,4'h0,0,0,0, 0,0,0,0,1,16'h1235,16'h0000));
      vecs.push_back(mk("z_start0",   0,1,1,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("z_start1",   0,1,1,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("z_evt",      1,1,1,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("z_nostrobe", 1,1,1,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("pa_press0",  0,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("pa_press1",  0,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("pa_evt",     1,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h1235,16'h0000));
      vecs.push_back(mk("pa_load",    1,1,0,0,4'h0,0,0,0, 2,0,0,1,0,16'h0000,16'h0000));
      vecs.push_back(mk("run_keyA",   0,1,0,1,4'hA,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("run_keyign", 0,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("pa_pzevt",   1,1,0,0,4'h0,0,0,0, 2,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("paused_keyA",1,1,0,1,4'hA,0,0,0, 3,0,0,0,0,16'h0000,16'h0000));
      vecs.push_back(mk("pa_clr",     1,1,0,0,4'h0,0,0,0, 0,0,0,0,1,16'h0000,16'h0000));
      vecs.push_back(mk("idle_end",   1,1,0,0,4'h0,0,0,0, 0,0,0,0,0,16'h0000,16'h0000));

      // Reset state while reseta is held low
      repeat (3) @(negedge clk);
      #1 check("reset_state", dut_out(), 41'h0);
      #1 reseta = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         pause         = vecs[i].p;
         cfg           = vecs[i].c;
         sel           = vecs[i].s;
         bus.key_valid = vecs[i].kv;
         bus.key_code  = vecs[i].kc;
         bus.tick      = vecs[i].t;
         bus.cnt_zero  = vecs[i].z;
         bus.cnt_max   = vecs[i].m;
         #1 check(vecs[i].nm, dut_out(), exp_out(vecs[i]));
      end

      // Enter a preset, start a count-up run, then reset asynchronously mid-run
      @(negedge clk);
      pause = 1'b1; cfg = 1'b1; sel = 1'b0;
      bus.key_valid = 1'b0; bus.tick = 1'b0; bus.cnt_zero = 1'b0; bus.cnt_max = 1'b0;
      press(1'b1);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'h7;
      @(negedge clk);
      bus.key_valid = 1'b0;
      press(1'b1);
      #1 check("preset_kept", {22'h0, state, preset}, {22'h0, 3'd0, 16'h0007});
      press(1'b0);
      #1 check("run_before_reset", {38'h0, state}, {38'h0, 3'd2});
      @(posedge clk);
      #3 reseta = 1'b0;
      #1 check("async_reset_midrun", dut_out(), 41'h0);
      repeat (2) @(negedge clk);
      #2 reseta = 1'b1;
      @(negedge clk);
      #1 check("post_reset_release", dut_out(), 41'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
